// File: rtl/instr_mem_loader.sv
// instr_mem_loader: RAM-backed instruction store. A streaming load port fills
// the RAM, and a registered fetch port reads it with a latency of one cycle.
// Any fetch outside the loaded program returns HALT_WORD and raises fetch_err.
// Optional feature macro: INSTR_MEM_PARITY_EN. It adds per-word even parity,
// the load_par_inj input and the sticky par_err output.
// state_dbg exposes the FSM state with these codes: 0=EMPTY, 1=LOAD, 2=READY.
//
// Handshake: load_valid has no ready. Every word presented with load_valid
// while loading, or together with load_start, is accepted in that cycle.
// fetch_req is always accepted. fetch_valid follows it exactly one cycle later.
module instr_mem_loader #(
  parameter int unsigned    DW        = 8,
  parameter int unsigned    AW        = 5,
  parameter int unsigned    DEPTH     = 32,
  parameter logic [DW-1:0]  HALT_WORD = 8'h0C
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_start,
  input  logic          load_valid,
  input  logic [DW-1:0] load_data,
  input  logic          load_last,
`ifdef INSTR_MEM_PARITY_EN
  input  logic          load_par_inj,
  output logic          par_err,
`endif
  output logic          load_done,
  output logic          busy,
  output logic [AW:0]   prog_len,
  input  logic          fetch_req,
  input  logic [AW-1:0] fetch_addr,
  output logic          fetch_valid,
  output logic [DW-1:0] fetch_data,
  output logic          fetch_err,
  output logic [1:0]    state_dbg
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2
  } state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);

  state_t        state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW:0]   prog_len_q, prog_len_d;
  logic          load_done_q, load_done_d;
  logic          busy_q, busy_d;
  logic          fetch_valid_q;
  logic [DW-1:0] fetch_data_q, fetch_data_d;
  logic          fetch_err_q, fetch_err_d;

  // The memory array has no reset. Words beyond prog_len are never returned.
  logic [DW-1:0] mem_q [DEPTH];

  logic          load_active;
  logic [AW-1:0] eff_wptr;
  logic          wr_en;
  logic          complete;
  logic          addr_ok;
  logic          fetch_hit;
  logic [DW-1:0] rd_word;

`ifdef INSTR_MEM_PARITY_EN
  logic          par_mem_q [DEPTH];
  logic          par_bad;
  logic          par_err_q, par_err_d;
`endif

  // Load path and FSM next state. load_start restarts the write pointer at 0,
  // so a word that arrives with it is written to address 0.
  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    prog_len_d  = prog_len_q;
    load_done_d = 1'b0;
    load_active = load_start || (state_q == ST_LOAD);
    eff_wptr    = load_start ? '0 : wptr_q;
    wr_en       = load_valid && load_active;
    complete    = wr_en && (load_last || (eff_wptr == LAST_IDX));
    if (load_start) begin
      state_d = ST_LOAD;
      wptr_d  = '0;
    end
    if (wr_en) begin
      wptr_d = eff_wptr + AW'(1);
    end
    if (complete) begin
      state_d     = ST_READY;
      prog_len_d  = {1'b0, eff_wptr} + (AW+1)'(1);
      load_done_d = 1'b1;
      wptr_d      = '0;
    end
    busy_d = (state_d == ST_LOAD);
  end

  // Fetch response. It is judged against the current (pre-edge) state, so any
  // fetch made while loading, including in the completion cycle, is invalid.
  always_comb begin
    addr_ok = (state_q == ST_READY) && ({1'b0, fetch_addr} < prog_len_q)
              && ({1'b0, fetch_addr} < DEPTH_W);
    rd_word = mem_q[fetch_addr];
`ifdef INSTR_MEM_PARITY_EN
    par_bad   = addr_ok && ((^rd_word) != par_mem_q[fetch_addr]);
    fetch_hit = addr_ok && !par_bad;
    par_err_d = load_start ? 1'b0 : (par_err_q || (fetch_req && par_bad));
`else
    fetch_hit = addr_ok;
`endif
    fetch_data_d = fetch_data_q;
    fetch_err_d  = fetch_err_q;
    if (fetch_req) begin
      fetch_data_d = fetch_hit ? rd_word : HALT_WORD;
      fetch_err_d  = !fetch_hit;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_EMPTY;
      wptr_q        <= '0;
      prog_len_q    <= '0;
      load_done_q   <= 1'b0;
      busy_q        <= 1'b0;
      fetch_valid_q <= 1'b0;
      fetch_data_q  <= HALT_WORD;
      fetch_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      wptr_q        <= wptr_d;
      prog_len_q    <= prog_len_d;
      load_done_q   <= load_done_d;
      busy_q        <= busy_d;
      fetch_valid_q <= fetch_req;
      fetch_data_q  <= fetch_data_d;
      fetch_err_q   <= fetch_err_d;
    end
  end

  // Memory write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[eff_wptr] <= load_data;
    end
  end

`ifdef INSTR_MEM_PARITY_EN
  // Parity store. load_par_inj flips the stored bit so an error can be forced.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      par_mem_q[eff_wptr] <= (^load_data) ^ load_par_inj;
    end
  end

  // Sticky parity error flag. It clears on reset or on a new load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= par_err_d;
    end
  end

  assign par_err = par_err_q;
`endif

  assign load_done   = load_done_q;
  assign busy        = busy_q;
  assign prog_len    = prog_len_q;
  assign fetch_valid = fetch_valid_q;
  assign fetch_data  = fetch_data_q;
  assign fetch_err   = fetch_err_q;
  assign state_dbg   = state_q;

endmodule
